// File: rtl/sub_serial.sv
// -----------------------------------------------------------------------------
// sub_serial -- multi-cycle serial subtractor.
//
// Computes diff = a - b - borrow_in (mod 2^WIDTH) by processing STEP bits per
// clock, LSB group first, over N = WIDTH/STEP clocks after the accept edge.
// Result outputs are registered and change only when an operation completes.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   STEP   bits processed per clock; must divide WIDTH exactly
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       request a subtraction (accepted when ready=1)
//   a, b        minuend / subtrahend, sampled on the accept edge only
//   borrow_in   initial borrow, sampled on the accept edge only
//   ready       a start will be accepted this cycle (IDLE or DONE)
//   valid       diff and flags hold a completed result
//   diff        a - b - borrow_in modulo 2^WIDTH
//   borrow_out  final borrow out of the MSB (unsigned a < b + borrow_in)
//   overflow    two's-complement overflow of the signed subtraction
//   zero        diff equals zero
// -----------------------------------------------------------------------------
module sub_serial #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;       // operands shift right; bits [STEP-1:0] are the current group
  logic [WIDTH-1:0] r_b;
  logic             r_bor;     // borrow carried between groups
  logic [WIDTH-1:0] r_acc;     // partial difference, filled from the MSB end
  logic             r_a_msb;   // sign bits kept for the overflow flag
  logic             r_b_msb;
  logic             r_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_overflow;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic [STEP-1:0]  w_grp_d;
  logic             w_bor_chain;
  logic [WIDTH-1:0] w_acc_next;

  assign ready    = (r_state != S_RUN);
  assign w_accept = start && ready;
  assign w_last   = (r_cnt == CNT_W'(N - 1));

  // Ripple-borrow across the STEP bits of the current group.
  // NOTE: every signal assigned in always_comb gets a default before any
  // conditional/loop update, so no path leaves it unassigned (no latch).
  always_comb begin
    w_grp_d     = '0;
    w_bor_chain = r_bor;
    for (int i = 0; i < STEP; i++) begin
      w_grp_d[i]  = r_a[i] ^ r_b[i] ^ w_bor_chain;
      w_bor_chain = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & w_bor_chain);
    end
  end

  // The new group enters at the top; after N shifts the LSB group has
  // arrived at bit 0 and r_acc holds the whole difference.
  generate
    if (STEP == WIDTH) begin : g_single
      assign w_acc_next = w_grp_d;
    end else begin : g_multi
      assign w_acc_next = {w_grp_d, r_acc[WIDTH-1:STEP]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_bor        <= 1'b0;
      r_acc        <= '0;
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_valid      <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_bor   <= borrow_in;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> STEP;
          r_b   <= r_b >> STEP;
          r_bor <= w_bor_chain;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state      <= S_DONE;
            r_valid      <= 1'b1;
            r_diff       <= w_acc_next;
            r_borrow_out <= w_bor_chain;
            r_overflow   <= (r_a_msb != r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
            r_zero       <= (w_acc_next == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid      = r_valid;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign overflow   = r_overflow;
  assign zero       = r_zero;

endmodule

// File: tb/tb_sub_serial.sv
// -----------------------------------------------------------------------------
// tb_sub_serial -- directed bench for sub_serial.
// Instance u_dut8 uses WIDTH=8/STEP=1, instance u_dut4 uses WIDTH=8/STEP=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sub_serial;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       borrow_in = 1'b0;

  logic       ready8, valid8, bout8, ovf8, zero8;
  logic [7:0] diff8;
  logic       ready4, valid4, bout4, ovf4, zero4;
  logic [7:0] diff4;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[8];

  always #5 clk = ~clk;

  sub_serial #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .borrow_in(borrow_in),
    .ready(ready8), .valid(valid8), .diff(diff8), .borrow_out(bout8),
    .overflow(ovf8), .zero(zero8)
  );

  sub_serial #(.WIDTH(8), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .borrow_in(borrow_in),
    .ready(ready4), .valid(valid4), .diff(diff4), .borrow_out(bout4),
    .overflow(ovf4), .zero(zero4)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Called right after the accept edge: drops start, then counts rising
  // edges until valid is seen (0 if it never appears within the budget).
  task automatic wait_valid(input bit sel, output int lat);
    lat = 0;
    @(negedge clk);
    start8 = 1'b0;
    start4 = 1'b0;
    check("valid_low_after_accept", sel ? valid4 : valid8, 0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ((sel ? valid4 : valid8) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input bit sel, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbin, output int lat);
    @(negedge clk);
    a         = ta;
    b         = tb_v;
    borrow_in = tbin;
    if (sel) start4 = 1'b1;
    else     start8 = 1'b1;
    @(posedge clk);
    wait_valid(sel, lat);
  endtask

  initial begin
    int lat;

    vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0, ov: 1'b0, z: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0, z: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1, z: 1'b0};
    vecs[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bo: 1'b0, ov: 1'b0, z: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bo: 1'b1, ov: 1'b1, z: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0, z: 1'b0};
    vecs[6] = '{a: 8'hA5, b: 8'h5A, bin: 1'b0, d: 8'h4B, bo: 1'b0, ov: 1'b1, z: 1'b0};
    vecs[7] = '{a: 8'h42, b: 8'h42, bin: 1'b0, d: 8'h00, bo: 1'b0, ov: 1'b0, z: 1'b1};

    // Reset state with the clock running.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  ready8, 1);
    check("rst_valid",  valid8, 0);
    check("rst_diff",   diff8,  0);
    check("rst_borrow", bout8,  0);
    check("rst_ovf",    ovf8,   0);
    check("rst_zero",   zero8,  0);
    check("rst_ready4", ready4, 1);
    rst = 1'b0;

    // Table-driven vectors, STEP=1.
    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      check($sformatf("v%0d_latency", i), lat,    8);
      check($sformatf("v%0d_diff", i),    diff8,  vecs[i].d);
      check($sformatf("v%0d_borrow", i),  bout8,  vecs[i].bo);
      check($sformatf("v%0d_ovf", i),     ovf8,   vecs[i].ov);
      check($sformatf("v%0d_zero", i),    zero8,  vecs[i].z);
      check($sformatf("v%0d_ready", i),   ready8, 1);
    end

    // Result holds in DONE while inputs wander and start stays low.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a         = 8'($urandom);
      b         = 8'($urandom);
      borrow_in = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d_valid", k), valid8, 1);
      check($sformatf("hold%0d_zero", k),  zero8,  1);
      check($sformatf("hold%0d_diff", k),  diff8,  8'h00);
    end

    // Start pulse and operand changes during RUN are ignored.
    @(negedge clk);
    a = 8'h05; b = 8'h03; borrow_in = 1'b0; start8 = 1'b1;
    @(posedge clk);                       // accept
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);                       // RUN edge 1
    @(posedge clk);                       // RUN edge 2
    @(negedge clk);
    check("run_ready_low", ready8, 0);
    start8 = 1'b1; a = 8'hFF; b = 8'h00; borrow_in = 1'b1;
    @(posedge clk);                       // RUN edge 3, start ignored
    @(negedge clk);
    start8 = 1'b0; a = 8'hAA; b = 8'h55;
    lat = 0;
    for (int k = 4; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid8 === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("ign_latency", lat,   8);
    check("ign_diff",    diff8, 8'h02);
    check("ign_borrow",  bout8, 0);
    check("ign_zero",    zero8, 0);

    // start held high: back-to-back operations.
    @(negedge clk);
    a = 8'h05; b = 8'h03; borrow_in = 1'b0; start8 = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid8 === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("b2b_first_latency", lat,   9);   // accept edge + 8 RUN edges
    check("b2b_first_diff",    diff8, 8'h02);
    a = 8'h10; b = 8'h0F; borrow_in = 1'b1;
    @(posedge clk);                       // re-accept after one DONE cycle
    @(negedge clk);
    check("b2b_reaccept_valid", valid8, 0);
    check("b2b_reaccept_ready", ready8, 0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid8 === 1'b1) begin
        lat = k;
        break;
      end
    end
    start8 = 1'b0;
    check("b2b_second_latency", lat,   8);
    check("b2b_second_diff",    diff8, 8'h00);
    check("b2b_second_zero",    zero8, 1);

    // Reset at RUN edge 3 aborts the operation.
    run_op(1'b0, 8'h00, 8'h01, 1'b0, lat);
    check("pre_rst_diff", diff8, 8'hFF);
    @(negedge clk);
    a = 8'h80; b = 8'h01; borrow_in = 1'b0; start8 = 1'b1;
    @(posedge clk);                       // accept
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);            // RUN edges 1..3
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_valid",  valid8, 0);
    check("abort_ready",  ready8, 1);
    check("abort_diff",   diff8,  0);
    check("abort_borrow", bout8,  0);
    check("abort_ovf",    ovf8,   0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("abort_hold%0d_valid", k), valid8, 0);
    end
    // Accept on the very first edge after reset is released.
    rst = 1'b0; a = 8'h10; b = 8'h0F; borrow_in = 1'b1; start8 = 1'b1;
    @(posedge clk);
    wait_valid(1'b0, lat);
    check("post_rst_latency", lat,   8);
    check("post_rst_diff",    diff8, 8'h00);
    check("post_rst_zero",    zero8, 1);

    // STEP=4 instance: two-edge latency.
    run_op(1'b1, 8'h3C, 8'h5A, 1'b0, lat);
    check("s4_latency", lat,   2);
    check("s4_diff",    diff4, 8'hE2);
    check("s4_borrow",  bout4, 1);
    check("s4_ovf",     ovf4,  0);
    check("s4_zero",    zero4, 0);
    run_op(1'b1, 8'h80, 8'h01, 1'b0, lat);
    check("s4b_latency", lat,   2);
    check("s4b_diff",    diff4, 8'h7F);
    check("s4b_ovf",     ovf4,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
